vx_alu_dotn: RTL

VX_ALU_DOTN -- requirements
Module: VX_alu_dotn

---
 rtl/vx_gpu_pkg.sv | 60 ++++++
 rtl/vx_dotn_lane.sv | 164 ++++++++++++++++
 rtl/vx_alu_dotn.sv | 93 +++++++++
 3 files changed

// File: rtl/vx_gpu_pkg.sv
// vx_gpu_pkg: shared constants and helpers for the packed dot-product ALU.
//
// Contents:
//   DOTN_MODE_*    operand packing encodings carried on in_mode
//   DOTN_NUM_PROD  number of multipliers per lane (8 with INT4x8, else 4)
//   dotn_elem()    extracts one packed element and extends it to 17 bits
//
// Build option: VX_ALU_DOTN_INT4_EN enables the INT4x8 packing. Without it,
// mode 1 is treated like the reserved mode and the INT4 extraction and the
// upper four multipliers are not built.
package vx_gpu_pkg;

  localparam logic [1:0] DOTN_MODE_INT8  = 2'd0;
  localparam logic [1:0] DOTN_MODE_INT4  = 2'd1;
  localparam logic [1:0] DOTN_MODE_INT16 = 2'd2;
  localparam logic [1:0] DOTN_MODE_RSVD  = 2'd3;

`ifdef VX_ALU_DOTN_INT4_EN
  localparam int DOTN_NUM_PROD = 8;
`else
  localparam int DOTN_NUM_PROD = 4;
`endif

  // Returns element idx of a packed 32-bit word, extended to 17 bits so a
  // single signed 17x17 multiplier covers every packing, signed or not.
  // Positions beyond the element count of the mode return 0, so they add
  // nothing to the lane sum.
  function automatic logic [16:0] dotn_elem(input logic [31:0] word,
                                            input logic [1:0]  mode,
                                            input logic        sgn,
                                            input int          idx);
    logic [16:0] e;
    logic [4:0]  base;
    e    = '0;
    base = '0;
    case (mode)
      DOTN_MODE_INT8: begin
        if (idx < 4) begin
          base = 5'((idx & 3) * 8);
          e    = {{9{sgn & word[base + 5'd7]}}, word[base +: 8]};
        end
      end
      DOTN_MODE_INT16: begin
        if (idx < 2) begin
          base = 5'((idx & 1) * 16);
          e    = {sgn & word[base + 5'd15], word[base +: 16]};
        end
      end
`ifdef VX_ALU_DOTN_INT4_EN
      DOTN_MODE_INT4: begin
        base = 5'((idx & 7) * 4);
        e    = {{13{sgn & word[base + 5'd3]}}, word[base +: 4]};
      end
`endif
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/vx_dotn_lane.sv
// vx_dotn_lane: one 32-bit lane of the packed dot product.
//
// Ports:
//   clk        rising-edge clock
//   adv        pipeline advance; every stage register loads when high
//   mode       packing (DOTN_MODE_*)
//   is_signed  1 = sign-extend elements
//   acc_en     1 = add rs3 to the sum
//   rs1, rs2   packed operands
//   rs3        full 32-bit addend
//   result     lane result, LATENCY register stages after the inputs
//
// Stage placement by LATENCY (the last register is always the result):
//   1: products and full reduction feed the result register
//   2: product register | reduction -> result
//   3: product register | pair-sum register | final sum -> result
//   4: operand register | product | pair-sum | result
// Data registers carry no reset; validity is tracked by the parent.
// Build option: VX_ALU_DOTN_INT4_EN (see vx_gpu_pkg).
module vx_dotn_lane
  import vx_gpu_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        adv,
  input  logic [1:0]  mode,
  input  logic        is_signed,
  input  logic        acc_en,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] rs3,
  output logic [31:0] result
);

  // ---------------- stage 0: operands ----------------
  logic [1:0]  s0_mode;
  logic        s0_signed;
  logic [31:0] s0_rs1;
  logic [31:0] s0_rs2;
  logic [31:0] s0_addend;
  logic [31:0] addend;

  assign addend = acc_en ? rs3 : 32'd0;

  generate
    if (LATENCY >= 4) begin : g_op_reg
      logic [1:0]  mode_reg;
      logic        signed_reg;
      logic [31:0] rs1_reg;
      logic [31:0] rs2_reg;
      logic [31:0] addend_reg;
      always_ff @(posedge clk) begin
        if (adv) begin
          mode_reg   <= mode;
          signed_reg <= is_signed;
          rs1_reg    <= rs1;
          rs2_reg    <= rs2;
          addend_reg <= addend;
        end
      end
      assign s0_mode   = mode_reg;
      assign s0_signed = signed_reg;
      assign s0_rs1    = rs1_reg;
      assign s0_rs2    = rs2_reg;
      assign s0_addend = addend_reg;
    end else begin : g_op_comb
      assign s0_mode   = mode;
      assign s0_signed = is_signed;
      assign s0_rs1    = rs1;
      assign s0_rs2    = rs2;
      assign s0_addend = addend;
    end
  endgenerate

  // ---------------- products ----------------
  // Only the low 32 bits of each product are needed since the lane result
  // wraps modulo 2^32.
  logic [31:0] prod [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_prod
      if (gi < DOTN_NUM_PROD) begin : g_mul
        logic signed [16:0] a;
        logic signed [16:0] b;
        logic signed [31:0] a_ext;
        logic signed [31:0] b_ext;
        assign a        = dotn_elem(s0_rs1, s0_mode, s0_signed, gi);
        assign b        = dotn_elem(s0_rs2, s0_mode, s0_signed, gi);
        assign a_ext    = 32'(a);
        assign b_ext    = 32'(b);
        assign prod[gi] = a_ext * b_ext;
      end else begin : g_zero
        assign prod[gi] = '0;
      end
    end
  endgenerate

  // ---------------- stage 1: product register ----------------
  logic [31:0] s1_prod [8];
  logic [31:0] s1_addend;

  generate
    if (LATENCY >= 2) begin : g_prod_reg
      logic [31:0] prod_reg [8];
      logic [31:0] addend_reg;
      always_ff @(posedge clk) begin
        if (adv) begin
          for (int i = 0; i < 8; i++) prod_reg[i] <= prod[i];
          addend_reg <= s0_addend;
        end
      end
      assign s1_prod   = prod_reg;
      assign s1_addend = addend_reg;
    end else begin : g_prod_comb
      assign s1_prod   = prod;
      assign s1_addend = s0_addend;
    end
  endgenerate

  // ---------------- pair sums ----------------
  logic [31:0] psum [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pair
      assign psum[gi] = s1_prod[2*gi] + s1_prod[2*gi+1];
    end
  endgenerate

  // ---------------- stage 2: pair-sum register ----------------
  logic [31:0] s2_psum [4];
  logic [31:0] s2_addend;

  generate
    if (LATENCY >= 3) begin : g_psum_reg
      logic [31:0] psum_reg [4];
      logic [31:0] addend_reg;
      always_ff @(posedge clk) begin
        if (adv) begin
          for (int i = 0; i < 4; i++) psum_reg[i] <= psum[i];
          addend_reg <= s1_addend;
        end
      end
      assign s2_psum   = psum_reg;
      assign s2_addend = addend_reg;
    end else begin : g_psum_comb
      assign s2_psum   = psum;
      assign s2_addend = s1_addend;
    end
  endgenerate

  // ---------------- final sum / result register ----------------
  logic [31:0] sum_next;
  logic [31:0] result_reg;

  assign sum_next = (s2_psum[0] + s2_psum[1]) + (s2_psum[2] + s2_psum[3]) + s2_addend;

  always_ff @(posedge clk) begin
    if (adv) result_reg <= sum_next;
  end

  assign result = result_reg;

endmodule

// File: rtl/vx_alu_dotn.sv
// vx_alu_dotn: NUM_LANES-wide packed dot-product ALU with valid/ready flow.
//
// Parameters:
//   NUM_LANES  number of 32-bit lanes
//   LATENCY    register stages from input to output, 1..4
//   TAG_WIDTH  width of the opaque request tag
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (accepted when both high)
//   in_mode, in_signed    packing and signedness of rs1/rs2 elements
//   in_acc_en             add rs3 to each lane sum
//   in_rs1/2/3            per-lane operands, lane i at [32i+31:32i]
//   in_tag                request tag, returned unchanged on out_tag
//   out_valid / out_ready result handshake
//   out_data, out_tag     result (don't-care while out_valid is low)
//
// All stages share one advance enable: the whole pipe moves when the output
// slot is empty or being drained, and freezes otherwise. Only the per-stage
// valid bits are reset; data and tag registers are left unreset.
// Build option: VX_ALU_DOTN_INT4_EN enables the INT4x8 mode.
module vx_alu_dotn #(
  parameter int NUM_LANES = 4,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic                     in_signed,
  input  logic                     in_acc_en,
  input  logic [NUM_LANES*32-1:0]  in_rs1,
  input  logic [NUM_LANES*32-1:0]  in_rs2,
  input  logic [NUM_LANES*32-1:0]  in_rs3,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_LANES*32-1:0]  out_data,
  output logic [TAG_WIDTH-1:0]     out_tag
);

  logic                 adv;
  logic [LATENCY-1:0]   vld_reg;
  logic [TAG_WIDTH-1:0] tag_reg [LATENCY];

  assign out_valid = vld_reg[LATENCY-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_tag   = tag_reg[LATENCY-1];

  // Valid and tag shift chains, one entry per stage.
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset)    vld_reg[0] <= 1'b0;
          else if (adv) vld_reg[0] <= in_valid;
        end
        always_ff @(posedge clk) begin
          if (adv) tag_reg[0] <= in_tag;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset)    vld_reg[gi] <= 1'b0;
          else if (adv) vld_reg[gi] <= vld_reg[gi-1];
        end
        always_ff @(posedge clk) begin
          if (adv) tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      vx_dotn_lane #(
        .LATENCY (LATENCY)
      ) u_lane (
        .clk       (clk),
        .adv       (adv),
        .mode      (in_mode),
        .is_signed (in_signed),
        .acc_en    (in_acc_en),
        .rs1       (in_rs1[32*gi +: 32]),
        .rs2       (in_rs2[32*gi +: 32]),
        .rs3       (in_rs3[32*gi +: 32]),
        .result    (out_data[32*gi +: 32])
      );
    end
  endgenerate

endmodule
